fuzz_stim_ctrl: RTL and testbench
=================================

FUZZ_STIM_CTRL -- requirements
Module: fuzz_stim_ctrl

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 cfg_seed  input  32  LCG seed, sampled on the accepted start.
REQ-005 cfg_cycles  input  16  additional vectors after the initial one, sampled on the accepted start.
REQ-006 start  input  1  level-sampled run request; honoured only in IDLE.
REQ-007 abort  input  1  cancels the run; highest priority after reset.
REQ-008 out_flat  input  330  DUT response bus.
REQ-009 in_flat  output  266  DUT stimulus bus, registered.
REQ-010 busy  output  1  high in FILL and APPLY.
REQ-011 done  output  1  one-cycle pulse at the end of the run.
REQ-012 signature  output  32  response compaction register.
REQ-013 vec_count  output  16  count of vectors applied in the current run.

Function
REQ-014 SHALL implement LCG step next = (s * 0x41C64E6D + 0x3039) mod 2^32, one step per clock.
REQ-015 SHALL have FSM states IDLE, FILL, APPLY and DONE.
REQ-016 IDLE with start=1: load rng=cfg_seed, slot=0, signature=0, vec_count=0, then go to FILL.
REQ-017 Each FILL cycle: rng <= next; next is written to the staging slot.
- Slots 0..7 receive in_flat bits [32k+31:32k].
- Slot 8 receives bits [265:256] = next[9:0].
REQ-018 After slot 8 is written, go to APPLY; the staging register is copied to in_flat on that same edge, so all 266 bits change atomically.
REQ-019 in_flat SHALL hold its value in every other cycle.
REQ-020 APPLY (1 cycle):
- signature <= rotl1(signature) XOR fold(out_flat).
- fold = XOR of the ten 32-bit slices [319:0] and zero-extended [329:320].
- vec_count increments (wraps modulo 2^16).
REQ-021 APPLY exit: if the incremented vec_count equals cfg_cycles+1 (17-bit compare), go to DONE; otherwise go to FILL with slot=0.
REQ-022 Run length: cfg_cycles=0 yields exactly one vector; cfg_cycles=0xFFFF yields 65536 vectors, and vec_count reads 0 at DONE.
REQ-023 DONE: done=1 for one cycle, then go to IDLE. Signature, in_flat and vec_count hold until the next accepted start.
REQ-024 Per-vector timing: 9 FILL cycles plus 1 APPLY cycle; done rises exactly 10*(cfg_cycles+1) cycles after busy first rises.
REQ-025 start outside IDLE SHALL be ignored; start held high through DONE SHALL begin a new run on the cycle after returning to IDLE.
REQ-026 abort=1 in FILL, APPLY or DONE: next state is IDLE, done is not pulsed, and in_flat, signature and vec_count hold.
REQ-027 abort=1 together with start=1 in IDLE: stay in IDLE.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL enter IDLE.
REQ-029 Reset values: in_flat=0, busy=0, done=0, signature=0, vec_count=0, rng=0, slot=0, staging=0.
REQ-030 Reset mid-run SHALL override abort and start and discard the run.

Structure
REQ-031 A shared package SHALL hold:
- LCG_MUL=0x41C64E6D and LCG_INC=0x3039.
- IN_W=266, OUT_W=330 and SLOTS=9.
- The FSM state enum.
REQ-032 The LCG step SHALL be a combinational sub-module lcg32_step (32-bit in, 32-bit out), reused by benches as the golden model.

Verification
REQ-033 Seed and first vector: cfg_seed=0, cfg_cycles=0, start pulse.
- Required: in_flat[31:0]=0x00003039 and in_flat[63:32]=0xD3DC167E.
- Required: done pulses 10 cycles after busy rises; vec_count=1.
REQ-034 Signature: out_flat tied to all zeros -> signature=0 after any run.
- out_flat=1 (bit 0 only), cfg_cycles=2 -> signature=0x00000007.
REQ-035 Run length: cfg_cycles=3 -> exactly 4 in_flat updates spaced 10 cycles apart, vec_count=4, and busy high for 40 cycles.
REQ-036 Abort and reset: abort asserted on the 5th FILL cycle of vector 2 -> IDLE next cycle with no done and vec_count=1.
- A later start with the same seed reproduces an identical in_flat sequence.
- rst_n=0 mid-APPLY -> all outputs read zero on the next cycle.
REQ-037 Start handling: start held high continuously with cfg_cycles=0 -> back-to-back runs, one done pulse every 12 cycles, and an identical signature each run for constant out_flat.
- start pulsed during busy -> no effect.

Source files
------------

// File: rtl/fuzz_stim_ctrl_pkg.sv
// Shared constants, FSM state type and response-compaction helpers for the
// fuzz stimulus controller and its LCG step.
package fuzz_stim_ctrl_pkg;

   localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
   localparam logic [31:0] LCG_INC = 32'h0000_3039;

   localparam int unsigned IN_W   = 266;
   localparam int unsigned OUT_W  = 330;
   localparam int unsigned SLOTS  = 9;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned TAIL_W = IN_W - (SLOTS - 1) * WORD_W;  // 10-bit last slot

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      APPLY = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic logic [31:0] rotl1(input logic [31:0] v);
      return {v[30:0], v[31]};
   endfunction

   // XOR of the ten full 32-bit response words and the zero-extended 10-bit tail.
   function automatic logic [31:0] fold_resp(input logic [OUT_W-1:0] r);
      logic [31:0] f;
      f = {22'd0, r[OUT_W-1 -: 10]};
      for (int i = 0; i < 10; i++) begin
         f = f ^ r[i*WORD_W +: WORD_W];
      end
      return f;
   endfunction

endpackage

// File: rtl/fuzz_stim_ctrl_if.sv
// Stimulus/response bus between a harness (master) and the fuzz controller (slave).
interface fuzz_stim_ctrl_if;
   import fuzz_stim_ctrl_pkg::*;

   logic [31:0]      cfg_seed;
   logic [15:0]      cfg_cycles;
   logic             start;
   logic             abort;
   logic [OUT_W-1:0] out_flat;
   logic [IN_W-1:0]  in_flat;
   logic             busy;
   logic             done;
   logic [31:0]      signature;
   logic [15:0]      vec_count;

   modport master (
      output cfg_seed, cfg_cycles, start, abort, out_flat,
      input  in_flat, busy, done, signature, vec_count
   );

   modport slave (
      input  cfg_seed, cfg_cycles, start, abort, out_flat,
      output in_flat, busy, done, signature, vec_count
   );

endinterface

// File: rtl/fuzz_stim_ctrl_lcg32_step.sv
// One combinational step of the 32-bit LCG: next = s * LCG_MUL + LCG_INC (mod 2^32).
module lcg32_step
   import fuzz_stim_ctrl_pkg::*;
(
   input  logic [31:0] state_i,
   output logic [31:0] state_o
);

   assign state_o = state_i * LCG_MUL + LCG_INC;

endmodule

// File: rtl/fuzz_stim_ctrl.sv
// Fuzz stimulus controller: fills a 266-bit vector from an LCG, applies it
// atomically, and compacts the DUT response into a rotating XOR signature.
module fuzz_stim_ctrl
   import fuzz_stim_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   fuzz_stim_ctrl_if.slave bus
);

   state_e          state_q,   state_d;
   logic [31:0]     rng_q,     rng_d;
   logic [3:0]      slot_q,    slot_d;
   logic [IN_W-1:0] staging_q, staging_d;
   logic [IN_W-1:0] in_flat_q, in_flat_d;
   logic [31:0]     sig_q,     sig_d;
   logic [15:0]     vec_q,     vec_d;
   logic [15:0]     cycles_q,  cycles_d;
   logic            busy_q,    busy_d;
   logic            done_q,    done_d;

   logic [31:0] rng_next;
   logic [8:0]  slot_base;
   logic [16:0] vec_inc;
   logic        last_vec;

   lcg32_step u_lcg (
      .state_i (rng_q),
      .state_o (rng_next)
   );

   assign slot_base = {1'b0, slot_q[2:0], 5'd0};
   // 17-bit count so a 0xFFFF cycle request still terminates after 65536 vectors.
   assign vec_inc   = {1'b0, vec_q} + 17'd1;
   assign last_vec  = (vec_inc == ({1'b0, cycles_q} + 17'd1));

   // NOTE: every *_d gets its hold value first, so partial assignments below never infer a latch.
   always_comb begin
      state_d   = state_q;
      rng_d     = rng_q;
      slot_d    = slot_q;
      staging_d = staging_q;
      in_flat_d = in_flat_q;
      sig_d     = sig_q;
      vec_d     = vec_q;
      cycles_d  = cycles_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               state_d  = FILL;
               rng_d    = bus.cfg_seed;
               slot_d   = 4'd0;
               sig_d    = 32'd0;
               vec_d    = 16'd0;
               cycles_d = bus.cfg_cycles;
            end
         end

         FILL: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               rng_d = rng_next;
               if (slot_q == 4'(SLOTS - 1)) begin
                  staging_d[IN_W-1 -: TAIL_W] = rng_next[TAIL_W-1:0];
                  in_flat_d = staging_d;
                  slot_d    = 4'd0;
                  state_d   = APPLY;
               end else begin
                  staging_d[slot_base +: WORD_W] = rng_next;
                  slot_d = slot_q + 4'd1;
               end
            end
         end

         APPLY: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               sig_d  = rotl1(sig_q) ^ fold_resp(bus.out_flat);
               vec_d  = vec_inc[15:0];
               slot_d = 4'd0;
               state_d = last_vec ? DONE : FILL;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status flags are registered from the next state so they align with it.
   assign busy_d = (state_d == FILL) || (state_d == APPLY);
   assign done_d = (state_d == DONE);

   // NOTE: sequential state uses non-blocking assignments only; the reset is
   // synchronous and also clears the wide staging register so stale data never leaks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rng_q     <= 32'd0;
         slot_q    <= 4'd0;
         staging_q <= '0;
         in_flat_q <= '0;
         sig_q     <= 32'd0;
         vec_q     <= 16'd0;
         cycles_q  <= 16'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rng_q     <= rng_d;
         slot_q    <= slot_d;
         staging_q <= staging_d;
         in_flat_q <= in_flat_d;
         sig_q     <= sig_d;
         vec_q     <= vec_d;
         cycles_q  <= cycles_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.in_flat   = in_flat_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.signature = sig_q;
   assign bus.vec_count = vec_q;

endmodule

// File: tb/tb_fuzz_stim_ctrl.sv
// Scoreboard bench for fuzz_stim_ctrl: directed runs push expected vectors and
// run results; a negedge monitor pops and compares them as the DUT produces them.
module tb_fuzz_stim_ctrl;
   import fuzz_stim_ctrl_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fuzz_stim_ctrl_if bus ();

   fuzz_stim_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [IN_W-1:0] v;
      int              off;
   } vec_rec_t;

   typedef struct {
      logic [31:0] sig;
      logic [15:0] vec;
      int          gap;
      int          period;
   } done_rec_t;

   vec_rec_t  vq[$];
   done_rec_t dq[$];

   task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lcg(input logic [31:0] s);
      return s * 32'h41C6_4E6D + 32'h0000_3039;
   endfunction

   task automatic gen_vec(inout logic [31:0] s, output logic [IN_W-1:0] v);
      v = '0;
      for (int j = 0; j < 9; j++) begin
         s = lcg(s);
         if (j < 8) v[j*32 +: 32] = s;
         else       v[265:256]    = s[9:0];
      end
   endtask

   task automatic expect_run(input logic [31:0] seed, input int nvec, input bit with_done,
                             input logic [31:0] sig, input int period);
      logic [31:0]     s;
      logic [IN_W-1:0] v;
      vec_rec_t        vr;
      done_rec_t       dr;
      s = seed;
      for (int k = 1; k <= nvec; k++) begin
         gen_vec(s, v);
         vr.v   = v;
         vr.off = 10 * k;
         vq.push_back(vr);
      end
      if (with_done) begin
         dr.sig    = sig;
         dr.vec    = 16'(nvec);
         dr.gap    = 10 * nvec;
         dr.period = period;
         dq.push_back(dr);
      end
   endtask

   // Monitor: vec_count stepping by one marks an APPLY; done marks run end.
   int          cyc = 0, rise = 0, busy_cnt = 0, last_done = 0;
   logic        prev_busy = 1'b0;
   logic [15:0] prev_vec  = 16'd0;

   always @(negedge clk) begin
      vec_rec_t  vr;
      done_rec_t dr;
      cyc++;
      if (rst_n) begin
         if (bus.busy && !prev_busy) begin
            rise     = cyc;
            busy_cnt = 0;
         end
         if (bus.busy) busy_cnt++;
         if (bus.vec_count == prev_vec + 16'd1) begin
            if (vq.size() == 0) begin
               total++; bad++;
               $display("FAIL vec_unexpected: got vec_count %0d want none", bus.vec_count);
            end else begin
               vr = vq.pop_front();
               check("in_flat", bus.in_flat, vr.v);
               check("vec_time", IN_W'(cyc - rise), IN_W'(vr.off));
            end
         end
         if (bus.done) begin
            if (dq.size() == 0) begin
               total++; bad++;
               $display("FAIL done_unexpected: got done sig %0h want none", bus.signature);
            end else begin
               dr = dq.pop_front();
               check("signature", IN_W'(bus.signature), IN_W'(dr.sig));
               check("vec_count", IN_W'(bus.vec_count), IN_W'(dr.vec));
               check("done_gap", IN_W'(cyc - rise), IN_W'(dr.gap));
               check("busy_len", IN_W'(busy_cnt), IN_W'(dr.gap));
               if (dr.period != 0)
                  check("done_period", IN_W'(cyc - last_done), IN_W'(dr.period));
            end
            last_done = cyc;
         end
      end
      prev_busy = bus.busy;
      prev_vec  = bus.vec_count;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [31:0] seed, input logic [15:0] cycles);
      bus.cfg_seed   = seed;
      bus.cfg_cycles = cycles;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic check_sb_empty(input string name);
      check({name, "_vq"}, IN_W'(vq.size()), '0);
      check({name, "_dq"}, IN_W'(dq.size()), '0);
   endtask

   initial begin
      logic [31:0]     s;
      logic [IN_W-1:0] v1;

      bus.cfg_seed   = '0;
      bus.cfg_cycles = '0;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.out_flat   = '0;
      repeat (3) tick();
      check("rst_in_flat", bus.in_flat, '0);
      check("rst_busy", IN_W'(bus.busy), '0);
      check("rst_done", IN_W'(bus.done), '0);
      check("rst_sig", IN_W'(bus.signature), '0);
      check("rst_vec", IN_W'(bus.vec_count), '0);
      rst_n = 1'b1;
      tick();

      // Seed 0, single vector, zero response.
      expect_run(32'd0, 1, 1'b1, 32'd0, 0);
      start_run(32'd0, 16'd0);
      repeat (12) tick();
      check("t1_word0", IN_W'(bus.in_flat[31:0]), IN_W'(32'h0000_3039));
      check("t1_word1", IN_W'(bus.in_flat[63:32]), IN_W'(32'hD3DC_167E));
      check_sb_empty("t1");

      // Single response bit over three vectors: 0 -> 1 -> 3 -> 7.
      bus.out_flat = OUT_W'(1);
      expect_run(32'h0000_1234, 3, 1'b1, 32'h0000_0007, 0);
      start_run(32'h0000_1234, 16'd2);
      repeat (32) tick();
      check_sb_empty("t2");

      // Tail-only response, four vectors, start pulses while busy are ignored.
      bus.out_flat = {10'h3FF, 320'd0};
      expect_run(32'hCAFE_BABE, 4, 1'b1, 32'h0000_1405, 0);
      start_run(32'hCAFE_BABE, 16'd3);
      repeat (4) tick();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      repeat (14) tick();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      repeat (24) tick();
      check("t3_idle", IN_W'(bus.busy), '0);
      check_sb_empty("t3");

      // Rotation wraps bit 31 into bit 0.
      bus.out_flat = OUT_W'(32'h8000_0001);
      expect_run(32'd7, 2, 1'b1, 32'h8000_0002, 0);
      start_run(32'd7, 16'd1);
      repeat (22) tick();
      check_sb_empty("t4");

      // Abort on the 5th FILL cycle of vector 2, then rerun with the same seed.
      bus.out_flat = '0;
      s = 32'hA5A5_A5A5;
      gen_vec(s, v1);
      expect_run(32'hA5A5_A5A5, 1, 1'b0, 32'd0, 0);
      start_run(32'hA5A5_A5A5, 16'd3);
      repeat (14) tick();
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("abort_busy", IN_W'(bus.busy), '0);
      check("abort_done", IN_W'(bus.done), '0);
      check("abort_vec", IN_W'(bus.vec_count), IN_W'(16'd1));
      check("abort_in_flat", bus.in_flat, v1);
      repeat (5) tick();
      expect_run(32'hA5A5_A5A5, 2, 1'b1, 32'd0, 0);
      start_run(32'hA5A5_A5A5, 16'd1);
      repeat (22) tick();
      check_sb_empty("t5");

      // Start held high: three back-to-back single-vector runs, 12 cycles apart.
      bus.out_flat = '0;
      bus.out_flat[31:0]    = 32'h8000_0000;
      bus.out_flat[63:32]   = 32'h0000_0001;
      bus.out_flat[319:288] = 32'h0F0F_0000;
      bus.out_flat[329:320] = 10'h2AA;
      expect_run(32'h55, 1, 1'b1, 32'h8F0F_02AB, 0);
      expect_run(32'h55, 1, 1'b1, 32'h8F0F_02AB, 12);
      expect_run(32'h55, 1, 1'b1, 32'h8F0F_02AB, 12);
      bus.cfg_seed   = 32'h55;
      bus.cfg_cycles = 16'd0;
      bus.start      = 1'b1;
      repeat (25) tick();
      bus.start = 1'b0;
      repeat (14) tick();
      check_sb_empty("t6");

      // Abort together with start in IDLE keeps the block idle and outputs held.
      bus.abort = 1'b1;
      bus.start = 1'b1;
      repeat (3) tick();
      check("abort_start_busy", IN_W'(bus.busy), '0);
      check("abort_start_sig", IN_W'(bus.signature), IN_W'(32'h8F0F_02AB));
      bus.abort = 1'b0;
      bus.start = 1'b0;
      tick();

      // Reset during the first APPLY clears every output.
      bus.out_flat = OUT_W'(1);
      start_run(32'h99, 16'd5);
      repeat (9) tick();
      rst_n = 1'b0;
      tick();
      check("rst_apply_in_flat", bus.in_flat, '0);
      check("rst_apply_busy", IN_W'(bus.busy), '0);
      check("rst_apply_done", IN_W'(bus.done), '0);
      check("rst_apply_sig", IN_W'(bus.signature), '0);
      check("rst_apply_vec", IN_W'(bus.vec_count), '0);
      rst_n = 1'b1;
      repeat (12) tick();
      check_sb_empty("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
